pulse_tracker: RTL and testbench
================================

PULSE_TRACKER -- requirements
Module: pulse_tracker

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16, giving the bit width of pulse-width and pulse-count values.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, giving the number of record entries (power of two, at least 2).
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 din  input  1  registered AND-stage output, synchronous to clk.
REQ-006 enable  input  1  tracking enable.
REQ-007 clear  input  1  synchronous flush of FIFO, count and flag.
REQ-008 rec_valid  output  1  head record available.
REQ-009 rec_ready  input  1  consumer accepts head record.
REQ-010 rec_width  output  CNT_W  high-pulse width in cycles of the head record.
REQ-011 pulse_cnt  output  CNT_W  completed pulses since reset or clear.
REQ-012 overflow  output  1  sticky flag: at least one record dropped.

Function
REQ-013 The FSM SHALL have two states, IDLE and HIGH, with din sampled on each posedge while enable=1.
REQ-014 In IDLE with din=1, the FSM SHALL move to HIGH and load the width counter with 1.
REQ-015 In HIGH with din=1, the FSM SHALL increment the width counter, saturating at 2^CNT_W-1 with no wrap.
REQ-016 In HIGH with din=0, the FSM SHALL complete the pulse: push the width counter value as a record, increment pulse_cnt, and return to IDLE.
REQ-017 pulse_cnt SHALL wrap modulo 2^CNT_W and SHALL count every completed pulse, including dropped ones.
REQ-018 A pulse completing at posedge N into an empty FIFO SHALL raise rec_valid with a valid rec_width from posedge N onward, visible in cycle N+1.
REQ-019 A record SHALL be popped on a posedge where rec_valid=1 and rec_ready=1.
REQ-020 rec_valid and rec_width SHALL stay stable while rec_valid=1 and rec_ready=0.
REQ-021 Records SHALL be delivered in completion order (FIFO).
REQ-022 When the FIFO is full:
- a push with a simultaneous pop SHALL succeed;
- a push without a pop SHALL be dropped and SHALL set overflow.
REQ-023 A push and a pop on a non-full, non-empty FIFO SHALL both take effect, leaving occupancy unchanged.
REQ-024 A push into an empty FIFO with rec_ready=1 SHALL NOT be popped in the same cycle.
REQ-025 When enable=0, the FSM SHALL be forced to IDLE and the width counter cleared; an in-progress pulse SHALL be discarded with no record and no count.
REQ-026 When enable=0, the FIFO SHALL still drain through rec_ready.
REQ-027 clear=1 SHALL have priority over every other event: the FIFO is emptied, pulse_cnt and overflow are zeroed, and the FSM goes to IDLE, all on the same posedge.
REQ-028 A pulse completing in the same cycle as clear=1 SHALL be discarded.
REQ-029 overflow SHALL remain 1 until clear or reset.

Reset
REQ-030 rst_n=0 SHALL immediately force the following, independent of clk:
- rec_valid=0, rec_width=0, pulse_cnt=0, overflow=0;
- FSM to IDLE, width counter to 0;
- FIFO empty.
REQ-031 Reset asserted mid-pulse or mid-transfer SHALL discard all state, with no record emitted after release.
REQ-032 After rst_n deasserts, the first posedge SHALL sample din normally; a din already high at that posedge SHALL start a pulse.

Structure
REQ-033 A shared package SHALL hold:
- CNT_W and FIFO_DEPTH defaults;
- the FSM state enumeration (IDLE, HIGH);
- the pointer width derived from FIFO_DEPTH.
REQ-034 The record buffer SHALL be a sub-module pulse_fifo with the following properties:
- parameterised width and depth;
- push/pop/full/empty ports;
- async active-low reset, synchronous flush.
REQ-035 The FSM, width counter, pulse_cnt and overflow logic SHALL reside in pulse_tracker.

Verification
REQ-036 Scenario: enable=1, rec_ready=1, din high for exactly 1 cycle -> one record with rec_width=1, and pulse_cnt=1.
REQ-037 Scenario: din pulses of 3, 5, 2 and 7 cycles with gaps of 1 cycle, rec_ready=0 -> FIFO full, rec_valid=1, overflow=0. Then one further 4-cycle pulse -> overflow=1 and pulse_cnt=5. Then set rec_ready=1 -> records pop in order 3, 5, 2, 7.
REQ-038 Scenario: CNT_W=4, din high for 20 cycles -> rec_width=15 (saturated).
REQ-039 Scenario: enable drops to 0 in cycle 3 of a high pulse -> no record, pulse_cnt unchanged. When enable returns with din still high -> a new pulse starts with width 1.
REQ-040 Scenario: FIFO holds 2 records and overflow=1; assert clear for 1 cycle during a pulse end -> rec_valid=0, pulse_cnt=0, overflow=0, no new record.
REQ-041 Scenario: rst_n low for 1 cycle mid-pulse with a record pending -> all outputs 0 immediately. After release, din still high -> a new record whose width is counted from the first post-reset posedge.

Source files
------------

// File: rtl/pulse_tracker_pkg.sv
// Shared definitions for the pulse tracker: default sizes, FSM states and
// the pointer-width helper used by the record FIFO.
package pulse_tracker_pkg;

   localparam int CNT_W_DEF      = 16;
   localparam int FIFO_DEPTH_DEF = 4;

   typedef enum logic {
      IDLE = 1'b0,
      HIGH = 1'b1
   } state_t;

   // Index width for a power-of-two buffer of the given depth (depth >= 2).
   function automatic int ptr_w(input int depth);
      return (depth <= 2) ? 1 : $clog2(depth);
   endfunction

   localparam int PTR_W_DEF = ptr_w(FIFO_DEPTH_DEF);

endpackage

// File: rtl/pulse_fifo.sv
// Small synchronous FIFO holding completed pulse records. A pop frees a slot
// in the same cycle, so a push into a full buffer succeeds when it coincides
// with a pop. The output reads zero whenever the buffer is empty.
module pulse_fifo
   import pulse_tracker_pkg::*;
#(
   parameter int W     = CNT_W_DEF,
   parameter int DEPTH = FIFO_DEPTH_DEF
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_flush,
   input  logic         i_push,
   input  logic [W-1:0] i_data,
   input  logic         i_pop,
   output logic [W-1:0] o_data,
   output logic         o_full,
   output logic         o_empty
);

   localparam int PW = ptr_w(DEPTH);

   logic [W-1:0]  r_mem [DEPTH];
   logic [PW-1:0] r_wr;
   logic [PW-1:0] r_rd;
   logic [PW:0]   r_cnt;

   logic w_do_pop;
   logic w_do_push;

   assign o_empty   = (r_cnt == '0);
   assign o_full    = (r_cnt == (PW+1)'(DEPTH));
   assign w_do_pop  = i_pop & ~o_empty;
   assign w_do_push = i_push & (~o_full | w_do_pop);
   assign o_data    = o_empty ? '0 : r_mem[r_rd];

   // Pointer and occupancy update; flush empties the buffer in one cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr  <= '0;
         r_rd  <= '0;
         r_cnt <= '0;
      end else if (i_flush) begin
         r_wr  <= '0;
         r_rd  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_do_push) r_wr <= r_wr + PW'(1);
         if (w_do_pop)  r_rd <= r_rd + PW'(1);
         unique case ({w_do_push, w_do_pop})
            2'b10:   r_cnt <= r_cnt + (PW+1)'(1);
            2'b01:   r_cnt <= r_cnt - (PW+1)'(1);
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   // Record storage; contents beyond the occupancy are never observed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (w_do_push && !i_flush) begin
         r_mem[r_wr] <= i_data;
      end
   end

endmodule

// File: rtl/pulse_tracker.sv
// Measures the width of high pulses on din, queues each completed width as a
// record for a ready/valid consumer, counts completed pulses and flags drops.
module pulse_tracker
   import pulse_tracker_pkg::*;
#(
   parameter int CNT_W      = CNT_W_DEF,
   parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             din,
   input  logic             enable,
   input  logic             clear,
   output logic             rec_valid,
   input  logic             rec_ready,
   output logic [CNT_W-1:0] rec_width,
   output logic [CNT_W-1:0] pulse_cnt,
   output logic             overflow
);

   state_t           r_state;
   logic [CNT_W-1:0] r_width;
   logic [CNT_W-1:0] r_pulse_cnt;
   logic             r_overflow;

   logic w_done;
   logic w_push;
   logic w_pop;
   logic w_full;
   logic w_empty;

   // A pulse ends on the first low sample while HIGH; clear discards it.
   assign w_done    = enable & (r_state == HIGH) & ~din;
   assign w_push    = w_done & ~clear;
   assign w_pop     = rec_ready & ~w_empty;
   assign rec_valid = ~w_empty;
   assign pulse_cnt = r_pulse_cnt;
   assign overflow  = r_overflow;

   pulse_fifo #(
      .W     (CNT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_flush (clear),
      .i_push  (w_push),
      .i_data  (r_width),
      .i_pop   (w_pop),
      .o_data  (rec_width),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   // Pulse FSM with saturating width counter; disable or clear abandons a pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_width <= '0;
      end else if (clear || !enable) begin
         r_state <= IDLE;
         r_width <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (din) begin
                  r_state <= HIGH;
                  r_width <= CNT_W'(1);
               end
            end
            HIGH: begin
               if (din) begin
                  if (r_width != '1) r_width <= r_width + CNT_W'(1);
               end else begin
                  r_state <= IDLE;
                  r_width <= '0;
               end
            end
            default: begin
               r_state <= IDLE;
               r_width <= '0;
            end
         endcase
      end
   end

   // Completed-pulse counter; counts dropped records too and wraps freely.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      r_pulse_cnt <= '0;
      else if (clear)  r_pulse_cnt <= '0;
      else if (w_done) r_pulse_cnt <= r_pulse_cnt + CNT_W'(1);
   end

   // Sticky drop flag: a completion into a full FIFO with no pop is lost.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                          r_overflow <= 1'b0;
      else if (clear)                      r_overflow <= 1'b0;
      else if (w_done && w_full && !w_pop) r_overflow <= 1'b1;
   end

endmodule

// File: tb/tb_pulse_tracker.sv
// Scoreboard bench for pulse_tracker: expected widths are queued as pulses
// are driven and checked whenever the consumer accepts a record.
module tb_pulse_tracker;

   localparam int CW = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          din = 1'b0;
   logic          enable = 1'b0;
   logic          clear = 1'b0;
   logic          rec_ready = 1'b0;
   logic          rec_valid;
   logic [CW-1:0] rec_width;
   logic [CW-1:0] pulse_cnt;
   logic          overflow;

   logic          din4 = 1'b0;
   logic          enable4 = 1'b0;
   logic          clear4 = 1'b0;
   logic          ready4 = 1'b0;
   logic          valid4;
   logic [3:0]    width4;
   logic [3:0]    cnt4;
   logic          ovf4;

   int            n_cmp  = 0;
   int            n_fail = 0;
   logic [CW-1:0] q_exp [$];
   logic [CW-1:0] exp_w;

   always #5 clk = ~clk;

   pulse_tracker #(.CNT_W(CW), .FIFO_DEPTH(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .din       (din),
      .enable    (enable),
      .clear     (clear),
      .rec_valid (rec_valid),
      .rec_ready (rec_ready),
      .rec_width (rec_width),
      .pulse_cnt (pulse_cnt),
      .overflow  (overflow)
   );

   pulse_tracker #(.CNT_W(4), .FIFO_DEPTH(2)) dut_sat (
      .clk       (clk),
      .rst_n     (rst_n),
      .din       (din4),
      .enable    (enable4),
      .clear     (clear4),
      .rec_valid (valid4),
      .rec_ready (ready4),
      .rec_width (width4),
      .pulse_cnt (cnt4),
      .overflow  (ovf4)
   );

   // Scoreboard: every accepted record must match the oldest expected width.
   always @(negedge clk) begin
      if (rst_n && rec_valid && rec_ready) begin
         n_cmp++;
         if (q_exp.size() == 0) begin
            n_fail++;
            $display("FAIL record_unexpected: got width %0d, none expected", rec_width);
         end else begin
            exp_w = q_exp.pop_front();
            if (rec_width !== exp_w) begin
               n_fail++;
               $display("FAIL record_order: got width %0d want %0d", rec_width, exp_w);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse(input int n, input int gap);
      din = 1'b1;
      repeat (n) cyc();
      din = 1'b0;
      repeat (gap) cyc();
   endtask

   task automatic do_clear();
      clear = 1'b1;
      cyc();
      clear = 1'b0;
      q_exp.delete();
   endtask

   task automatic test_reset();
      #3;
      n_cmp++; if (rec_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", rec_valid); end
      n_cmp++; if (rec_width !== '0)   begin n_fail++; $display("FAIL reset_width: got %0d want 0", rec_width); end
      n_cmp++; if (pulse_cnt !== '0)   begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", pulse_cnt); end
      n_cmp++; if (overflow !== 1'b0)  begin n_fail++; $display("FAIL reset_ovf: got %b want 0", overflow); end
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      enable = 1'b1;
      enable4 = 1'b1;
      cyc();
   endtask

   task automatic test_single();
      rec_ready = 1'b1;
      q_exp.push_back(CW'(1));
      din = 1'b1;
      cyc();
      din = 1'b0;
      cyc();
      n_cmp++; if (rec_valid !== 1'b1)   begin n_fail++; $display("FAIL single_valid: got %b want 1", rec_valid); end
      n_cmp++; if (rec_width !== CW'(1)) begin n_fail++; $display("FAIL single_width: got %0d want 1", rec_width); end
      cyc();
      n_cmp++; if (rec_valid !== 1'b0)   begin n_fail++; $display("FAIL single_drained: got %b want 0", rec_valid); end
      n_cmp++; if (pulse_cnt !== CW'(1)) begin n_fail++; $display("FAIL single_cnt: got %0d want 1", pulse_cnt); end
   endtask

   task automatic test_fill_overflow();
      int widths [4] = '{3, 5, 2, 7};
      rec_ready = 1'b0;
      do_clear();
      foreach (widths[i]) begin
         q_exp.push_back(CW'(widths[i]));
         pulse(widths[i], 1);
      end
      n_cmp++; if (rec_valid !== 1'b1)   begin n_fail++; $display("FAIL full_valid: got %b want 1", rec_valid); end
      n_cmp++; if (overflow !== 1'b0)    begin n_fail++; $display("FAIL full_no_ovf: got %b want 0", overflow); end
      repeat (2) cyc();
      n_cmp++; if (rec_width !== CW'(3)) begin n_fail++; $display("FAIL stall_stable: got %0d want 3", rec_width); end
      pulse(4, 1);
      n_cmp++; if (overflow !== 1'b1)    begin n_fail++; $display("FAIL drop_ovf: got %b want 1", overflow); end
      n_cmp++; if (pulse_cnt !== CW'(5)) begin n_fail++; $display("FAIL drop_cnt: got %0d want 5", pulse_cnt); end
      rec_ready = 1'b1;
      repeat (6) cyc();
      n_cmp++; if (q_exp.size() != 0)    begin n_fail++; $display("FAIL fill_drain: got %0d pending want 0", q_exp.size()); end
      n_cmp++; if (rec_valid !== 1'b0)   begin n_fail++; $display("FAIL fill_empty: got %b want 0", rec_valid); end
      n_cmp++; if (overflow !== 1'b1)    begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
   endtask

   task automatic test_back_to_back();
      int widths [4] = '{3, 5, 2, 7};
      rec_ready = 1'b0;
      do_clear();
      foreach (widths[i]) begin
         q_exp.push_back(CW'(widths[i]));
         pulse(widths[i], 1);
      end
      q_exp.push_back(CW'(2));
      din = 1'b1;
      repeat (2) cyc();
      din = 1'b0;
      rec_ready = 1'b1;
      cyc();
      n_cmp++; if (overflow !== 1'b0)  begin n_fail++; $display("FAIL full_push_pop_ovf: got %b want 0", overflow); end
      n_cmp++; if (rec_valid !== 1'b1) begin n_fail++; $display("FAIL full_push_pop_valid: got %b want 1", rec_valid); end
      repeat (6) cyc();
      n_cmp++; if (q_exp.size() != 0)  begin n_fail++; $display("FAIL b2b_drain: got %0d pending want 0", q_exp.size()); end
      // Draining while tracking is disabled.
      rec_ready = 1'b0;
      q_exp.push_back(CW'(2));
      pulse(2, 1);
      enable = 1'b0;
      rec_ready = 1'b1;
      repeat (2) cyc();
      n_cmp++; if (rec_valid !== 1'b0) begin n_fail++; $display("FAIL disabled_drain: got %b want 0", rec_valid); end
      enable = 1'b1;
   endtask

   task automatic test_saturate();
      din4 = 1'b1;
      repeat (20) cyc();
      din4 = 1'b0;
      cyc();
      n_cmp++; if (valid4 !== 1'b1)  begin n_fail++; $display("FAIL sat_valid: got %b want 1", valid4); end
      n_cmp++; if (width4 !== 4'd15) begin n_fail++; $display("FAIL sat_width: got %0d want 15", width4); end
      n_cmp++; if (cnt4 !== 4'd1)    begin n_fail++; $display("FAIL sat_cnt: got %0d want 1", cnt4); end
   endtask

   task automatic test_enable_drop();
      rec_ready = 1'b1;
      do_clear();
      din = 1'b1;
      repeat (2) cyc();
      enable = 1'b0;
      repeat (2) cyc();
      n_cmp++; if (pulse_cnt !== '0)   begin n_fail++; $display("FAIL en_drop_cnt: got %0d want 0", pulse_cnt); end
      n_cmp++; if (rec_valid !== 1'b0) begin n_fail++; $display("FAIL en_drop_valid: got %b want 0", rec_valid); end
      enable = 1'b1;
      cyc();
      q_exp.push_back(CW'(1));
      din = 1'b0;
      cyc();
      n_cmp++; if (rec_width !== CW'(1)) begin n_fail++; $display("FAIL en_restart_width: got %0d want 1", rec_width); end
      cyc();
      n_cmp++; if (pulse_cnt !== CW'(1)) begin n_fail++; $display("FAIL en_restart_cnt: got %0d want 1", pulse_cnt); end
   endtask

   task automatic test_clear();
      rec_ready = 1'b0;
      do_clear();
      for (int i = 0; i < 5; i++) begin
         q_exp.push_back(CW'(i + 2));
         pulse(i + 2, 1);
      end
      void'(q_exp.pop_back());
      rec_ready = 1'b1;
      repeat (2) cyc();
      rec_ready = 1'b0;
      n_cmp++; if (overflow !== 1'b1)  begin n_fail++; $display("FAIL clr_pre_ovf: got %b want 1", overflow); end
      din = 1'b1;
      repeat (2) cyc();
      din = 1'b0;
      clear = 1'b1;
      cyc();
      clear = 1'b0;
      q_exp.delete();
      n_cmp++; if (rec_valid !== 1'b0) begin n_fail++; $display("FAIL clr_valid: got %b want 0", rec_valid); end
      n_cmp++; if (pulse_cnt !== '0)   begin n_fail++; $display("FAIL clr_cnt: got %0d want 0", pulse_cnt); end
      n_cmp++; if (overflow !== 1'b0)  begin n_fail++; $display("FAIL clr_ovf: got %b want 0", overflow); end
      repeat (2) cyc();
      n_cmp++; if (rec_valid !== 1'b0) begin n_fail++; $display("FAIL clr_no_record: got %b want 0", rec_valid); end
   endtask

   task automatic test_reset_mid();
      rec_ready = 1'b0;
      do_clear();
      pulse(2, 1);
      din = 1'b1;
      repeat (2) cyc();
      #2 rst_n = 1'b0;
      #1;
      n_cmp++; if (rec_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid: got %b want 0", rec_valid); end
      n_cmp++; if (rec_width !== '0)   begin n_fail++; $display("FAIL rst_mid_width: got %0d want 0", rec_width); end
      n_cmp++; if (pulse_cnt !== '0)   begin n_fail++; $display("FAIL rst_mid_cnt: got %0d want 0", pulse_cnt); end
      n_cmp++; if (overflow !== 1'b0)  begin n_fail++; $display("FAIL rst_mid_ovf: got %b want 0", overflow); end
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (3) cyc();
      q_exp.push_back(CW'(3));
      din = 1'b0;
      rec_ready = 1'b1;
      repeat (2) cyc();
      n_cmp++; if (q_exp.size() != 0)    begin n_fail++; $display("FAIL rst_post_record: got %0d pending want 0", q_exp.size()); end
      n_cmp++; if (pulse_cnt !== CW'(1)) begin n_fail++; $display("FAIL rst_post_cnt: got %0d want 1", pulse_cnt); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_fill_overflow();
      test_back_to_back();
      test_saturate();
      test_enable_drop();
      test_clear();
      test_reset_mid();
      repeat (2) cyc();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
